// File: rtl/rv_pkg.sv
// Shared RV32 integer-core constants and types used by the register file slice.
// Widths here set the defaults for the interface and for every register-file module.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 is hardwired, so a write only lands when enabled and aimed elsewhere
  function automatic logic writeLands(input logic we, input reg_idx_t rd);
    return we && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Register-file access bus: two read ports and one write port.
// The master modport is the decode/execute side; the slave modport is the register file itself.
interface register_file_if
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int ADDR_W = rv_pkg::REG_ADDR_W
) ();

  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]   write_data;
  logic              reg_write;
  logic [XLEN-1:0]   read_data1;
  logic [XLEN-1:0]   read_data2;

  modport master (
    output read_reg1,
    output read_reg2,
    output write_reg,
    output write_data,
    output reg_write,
    input  read_data1,
    input  read_data2
  );

  modport slave (
    input  read_reg1,
    input  read_reg2,
    input  write_reg,
    input  write_data,
    input  reg_write,
    output read_data1,
    output read_data2
  );

endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: x0 forces zero, then a same-cycle write is bypassed,
// otherwise stored contents are returned. Instantiated once per port so both behave identically.
module reg_read_port
  import rv_pkg::*;
#(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NUM_REGS = rv_pkg::NUM_REGS,
  parameter int ADDR_W   = rv_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] read_reg_i,
  input  logic [ADDR_W-1:0] write_reg_i,
  input  logic              reg_write_i,
  input  logic [XLEN-1:0]   write_data_i,
  input  logic [XLEN-1:0]   regs_i [NUM_REGS],
  output logic [XLEN-1:0]   read_data_o
);

  // Bypass ignores reset on purpose: forwarding stays live even while storage is held clear
  always_comb begin
    read_data_o = regs_i[read_reg_i];
    if (read_reg_i == REG_ZERO) begin
      read_data_o = '0;
    end else if (reg_write_i && (write_reg_i == read_reg_i)) begin
      read_data_o = write_data_i;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x XLEN RISC-V integer register file: x0 hardwired to zero, one synchronous write port,
// two combinational write-first read ports feeding the ALU A input and ALU-source mux.
module register_file
  import rv_pkg::*;
#(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NUM_REGS = rv_pkg::NUM_REGS,
  parameter int ADDR_W   = rv_pkg::REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  register_file_if.slave bus
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Entry 0 is never written, so it stays at its reset value of zero
  always_comb begin
    regs_d = regs_q;
    if (writeLands(bus.reg_write, bus.write_reg)) begin
      regs_d[bus.write_reg] = bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port1 (
    .read_reg_i   (bus.read_reg1),
    .write_reg_i  (bus.write_reg),
    .reg_write_i  (bus.reg_write),
    .write_data_i (bus.write_data),
    .regs_i       (regs_q),
    .read_data_o  (bus.read_data1)
  );

  reg_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port2 (
    .read_reg_i   (bus.read_reg2),
    .write_reg_i  (bus.write_reg),
    .reg_write_i  (bus.reg_write),
    .write_data_i (bus.write_data),
    .regs_i       (regs_q),
    .read_data_o  (bus.read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed-vector and reference-model bench for register_file.
// Inputs change just after the falling edge; outputs are checked before the next rising edge.
module tb_register_file;

  logic clk = 1'b0;
  logic rst_n;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model [32];

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[14];

  task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    bus.reg_write  = we;
    bus.write_reg  = wr;
    bus.write_data = wd;
    bus.read_reg1  = rs1;
    bus.read_reg2  = rs2;
    if (we === 1'b1 && $isunknown(wr)) begin
      mismatched++;
      $display("[TB] FAIL x_on_write_reg: write_reg=%b with reg_write=1, required a known index", wr);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] expectedAfterTable(input int idx);
    case (idx)
      1:       return 32'h12345678;
      5:       return 32'hDEADBEEF;
      7:       return 32'h22222222;
      12:      return 32'h0BADF00D;
      31:      return 32'hFFFFFFFF;
      default: return 32'h00000000;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{"wr_x1_bypass",       1'b1, 5'd1,  32'h12345678, 5'd1,  5'd31, 32'h12345678, 32'h00000000};
    vecs[1]  = '{"wr_x31_bypass",      1'b1, 5'd31, 32'hFFFFFFFF, 5'd1,  5'd31, 32'h12345678, 32'hFFFFFFFF};
    vecs[2]  = '{"rd_x1_x31",          1'b0, 5'd0,  32'h00000000, 5'd1,  5'd31, 32'h12345678, 32'hFFFFFFFF};
    vecs[3]  = '{"rd_unwritten",       1'b0, 5'd0,  32'h00000000, 5'd2,  5'd30, 32'h00000000, 32'h00000000};
    vecs[4]  = '{"wr_x0_same_cycle",   1'b1, 5'd0,  32'hAAAAAAAA, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[5]  = '{"rd_x0_next_cycle",   1'b0, 5'd0,  32'hAAAAAAAA, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[6]  = '{"wr_x7_first",        1'b1, 5'd7,  32'h11111111, 5'd7,  5'd1,  32'h11111111, 32'h12345678};
    vecs[7]  = '{"bypass_x7_new",      1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222};
    vecs[8]  = '{"rd_x7_after_edge",   1'b0, 5'd7,  32'h22222222, 5'd7,  5'd0,  32'h22222222, 32'h00000000};
    vecs[9]  = '{"no_bypass_disabled", 1'b0, 5'd7,  32'h33333333, 5'd7,  5'd7,  32'h22222222, 32'h22222222};
    vecs[10] = '{"dual_same_bypass",   1'b1, 5'd12, 32'h0BADF00D, 5'd12, 5'd12, 32'h0BADF00D, 32'h0BADF00D};
    vecs[11] = '{"rd_x12_x31",         1'b0, 5'd0,  32'h00000000, 5'd12, 5'd31, 32'h0BADF00D, 32'hFFFFFFFF};
    vecs[12] = '{"wr_x5_port2_bypass", 1'b1, 5'd5,  32'hDEADBEEF, 5'd6,  5'd5,  32'h00000000, 32'hDEADBEEF};
    vecs[13] = '{"rd_x5_x12",          1'b0, 5'd0,  32'h00000000, 5'd5,  5'd12, 32'hDEADBEEF, 32'h0BADF00D};

    // Reset state, checked while reset is held
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #2;
    checkOutput("reset_rd1", bus.read_data1, 32'h0);
    checkOutput("reset_rd2", bus.read_data2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].rs1, vecs[i].rs2);
      #1;
      checkOutput({vecs[i].name, "_rd1"}, bus.read_data1, vecs[i].exp1);
      checkOutput({vecs[i].name, "_rd2"}, bus.read_data2, vecs[i].exp2);
    end

    // Whole-file sweep: only the table's targets hold data
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      checkOutput($sformatf("sweep_rd1_x%0d", i), bus.read_data1, expectedAfterTable(i));
      checkOutput($sformatf("sweep_rd2_x%0d", 31 - i), bus.read_data2, expectedAfterTable(31 - i));
    end

    // Mid-run reset clears x5 immediately, without a clock edge
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
    #1;
    checkOutput("pre_reset_x5", bus.read_data1, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_x5", bus.read_data1, 32'h0);
    checkOutput("async_reset_x1", bus.read_data2, 32'h0);

    // Bypass still forwards during reset, but the write is not stored
    applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0);
    #1;
    checkOutput("reset_bypass_x9", bus.read_data1, 32'hCAFEF00D);
    @(negedge clk);
    applyStimulus(1'b0, 5'd9, 32'hCAFEF00D, 5'd9, 5'd5);
    #1;
    checkOutput("reset_drop_x9", bus.read_data1, 32'h0);
    checkOutput("reset_still_x5", bus.read_data2, 32'h0);

    // First rising edge after release accepts a write
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h01020304, 5'd0, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
    #1;
    checkOutput("first_write_x3", bus.read_data1, 32'h01020304);
    checkOutput("post_reset_x9", bus.read_data2, 32'h0);

    // Random sweep against a reference model of the write-first register file
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[3] = 32'h01020304;
    for (int n = 0; n < 1000; n++) begin
      logic        we;
      logic [4:0]  wr, rs1, rs2;
      logic [31:0] wd, e1, e2;
      @(negedge clk);
      we  = 1'($urandom_range(0, 1));
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = (n % 4 == 0) ? rs1 : 5'($urandom_range(0, 31));
      applyStimulus(we, wr, wd, rs1, rs2);
      e1 = (rs1 == 5'd0) ? 32'h0 : (we && wr == rs1) ? wd : model[rs1];
      e2 = (rs2 == 5'd0) ? 32'h0 : (we && wr == rs2) ? wd : model[rs2];
      #1;
      checkOutput($sformatf("rand%0d_rd1_x%0d", n, rs1), bus.read_data1, e1);
      checkOutput($sformatf("rand%0d_rd2_x%0d", n, rs2), bus.read_data2, e2);
      @(posedge clk);
      if (we && wr != 5'd0) model[wr] = wd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
